// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI-Stream FIFO storing {tlast, tdata},
// with word occupancy and complete-packet counts.
module axis_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [DW-1:0]              m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DW:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] pkt_count_r;
    logic          full_s;
    logic          empty_s;
    logic          wr_en_s;
    logic          rd_en_s;

    // Status flags come from the registered pointers only; the extra MSB tells full from empty.
    assign full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign count    = wr_ptr_r - rd_ptr_r;
    assign full     = full_s;
    assign empty    = empty_s;
    assign pkt_count = pkt_count_r;

    assign s_tready = !full_s && !rst;
    assign m_tvalid = !empty_s;
    assign {m_tlast, m_tdata} = mem_r[rd_ptr_r[AW-1:0]];

    assign wr_en_s = s_tvalid && s_tready;
    assign rd_en_s = m_tvalid && m_tready;

    // Storage array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {s_tlast, s_tdata};
        end
    end

    // Extended pointers roll over naturally in binary.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Complete-packet counter: a tlast beat in and a tlast beat out in one cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_r <= {PW{1'b0}};
        end else begin
            case ({wr_en_s && s_tlast, rd_en_s && m_tlast})
                2'b10:   pkt_count_r <= pkt_count_r + PW'(1);
                2'b01:   pkt_count_r <= pkt_count_r - PW'(1);
                default: pkt_count_r <= pkt_count_r;
            endcase
        end
    end

endmodule

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Single-clock AXI-Stream FIFO that buffers the merged output of the 2:1 stream selector before the downstream consumer. It absorbs backpressure bursts and stores tdata with tlast. It reports word occupancy and the number of complete packets held, so a consumer can wait for a whole packet before draining. Reads are first-word-fall-through: the head entry is always presented on the master port.

## Interface
- DW, 8, tdata width in bits
- DEPTH, 16, number of entries; must be a power of two, ≥ 2
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- s_tdata  in  DW  write data
- s_tvalid  in  1  write valid
- s_tlast  in  1  last beat of packet
- s_tready  out  1  FIFO accepts a beat
- m_tdata  out  DW  head-of-FIFO data
- m_tvalid  out  1  FIFO non-empty
- m_tlast  out  1  head-of-FIFO tlast
- m_tready  in  1  consumer accepts the beat
- count  out  $clog2(DEPTH)+1  words stored, 0..DEPTH
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored (tlast beats), 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH × (DW+1) array holding {tlast, tdata}. The array is not reset.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide.
  - The low bits address the array; the MSB is the wrap bit.
  - full when the addresses are equal and the MSBs differ; empty when the pointers are equal.
- count = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Write fires on s_tvalid && s_tready. The entry is stored at wr_ptr[low] and wr_ptr increments.
- Read fires on m_tvalid && m_tready. rd_ptr increments.
- s_tready = !full && !rst. A full FIFO does not accept a write even when a read fires in the same cycle.
- m_tvalid = !empty. m_tdata/m_tlast = array[rd_ptr[low]] (combinational read).
- m_tdata/m_tlast are don't-care while m_tvalid = 0; the bench must not check them then.
- pkt_count (registered):
  - +1 on a write with s_tlast = 1.
  - −1 on a read with m_tlast = 1.
  - Unchanged when both happen in the same cycle.
- Pointer wrap: natural binary rollover of the extended pointers; no special case at DEPTH−1 → 0.
- Reset (rst = 1 at a clock edge):
  - wr_ptr = rd_ptr = 0, pkt_count = 0.
  - Resulting outputs: count = 0, empty = 1, full = 0, m_tvalid = 0.
  - s_tready = 0 while rst is high and 1 in the first cycle after deassertion.
  - Reset mid-packet discards all contents, including partial packets. No beat is emitted after reset until a new write.
- Producer rule: a producer may hold s_tvalid with no s_tready. The FIFO never drops or duplicates beats.
- FIFO output rule: once m_tvalid is high, it and m_tdata stay stable until the read fires.

## Timing
- Write-to-read latency: 1 cycle.
  - A beat written at edge N appears with m_tvalid = 1 after edge N.
  - It can be read at edge N+1.
- Throughput: 1 beat/cycle sustained when neither full nor empty.
- Boundary behaviours:
  - Empty with write and m_tready both high: only the write occurs; no read.
  - Full with read and write both requested: only the read occurs. s_tready rises the cycle after.
- count, full, empty, pkt_count update on the same edge as the pointer change. They are register-derived with no combinational path from s_tvalid or m_tready.
- s_tready depends only on registered state and rst. There is no combinational path from m_tready to s_tready.

## Test plan
All scenarios use DW = 8, DEPTH = 4.
- Reset: hold rst 3 cycles, then release → during rst, s_tready = 0, m_tvalid = 0, count = 0, empty = 1. The cycle after release, s_tready = 1.
- Fill to full with m_tready = 0, writing 0x11, 0x22, 0x33, 0x44 (tlast on 0x44):
  - After the 4th edge: count = 4, full = 1, s_tready = 0, pkt_count = 1.
  - A 5th beat 0x55 is held and not accepted.
- Drain the full FIFO: raise m_tready → reads 0x11, 0x22, 0x33, 0x44 on consecutive edges, m_tlast = 1 only on 0x44. Then pkt_count = 0, empty = 1. 0x55 is accepted the cycle after the first read.
- Streaming wrap: 20 beats 0x00..0x13 with s_tvalid and m_tready both high continuously → output order is 0x00..0x13 with no gaps after the first-cycle latency; count stays ≤ 1; the pointers wrap 5 times.
- Random backpressure: 200 beats with random s_tvalid/m_tready (50% each) and tlast every 7 beats →
  - the output sequence equals the input sequence;
  - pkt_count always equals the number of stored beats with tlast;
  - m_tdata never changes while m_tvalid && !m_tready.
- Reset mid-packet: write 0xA1, 0xA2 (no tlast), assert rst for 1 cycle → count = 0, pkt_count = 0, m_tvalid = 0. A subsequent write 0xB1 is read first.
